// File: rtl/iram_pkg.sv
// Shared types and sizing helpers for the loadable instruction RAM.
// The default geometry constants are also used by the CPU top level.
package iram_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    FILL = 2'd2
  } ld_state_t;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_DEPTH  = 128;
  localparam int DEF_ADDR_W = 8;

  function automatic int bpw(input int data_w);
    return data_w / 8;
  endfunction

  // Minimum one bit, so a 1-value index still has a legal declaration.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int off_w(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/iram_byte_packer.sv
// Assembles an MSB-first byte stream into words. A word is presented on the
// byte that completes it, or early on the last byte with the low bytes zero.
module iram_byte_packer
  import iram_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              clr,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  input  logic              byte_last,
  output logic              word_valid,
  output logic [DATA_W-1:0] word
);

  localparam int BPW    = bpw(DATA_W);
  localparam int BIDX_W = idx_w(BPW);

  logic [BIDX_W-1:0] byte_idx_q, byte_idx_d;
  logic [DATA_W-1:0] assy_q, assy_d;
  logic              at_last_pos;

  // The assembly register is cleared after every word, so unfilled low bytes
  // are already zero when LD_LAST cuts a word short.
  always_comb begin
    at_last_pos = (byte_idx_q == BIDX_W'(BPW - 1));
    word        = assy_q | (DATA_W'(byte_data) << (8 * (BPW - 1 - int'(byte_idx_q))));
    word_valid  = byte_valid & (at_last_pos | byte_last);
    byte_idx_d  = byte_idx_q;
    assy_d      = assy_q;
    if (clr) begin
      byte_idx_d = '0;
      assy_d     = '0;
    end else if (byte_valid) begin
      if (word_valid) begin
        byte_idx_d = '0;
        assy_d     = '0;
      end else begin
        byte_idx_d = byte_idx_q + 1'b1;
        assy_d     = word;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      byte_idx_q <= '0;
      assy_q     <= '0;
    end else begin
      byte_idx_q <= byte_idx_d;
      assy_q     <= assy_d;
    end
  end

endmodule

// File: rtl/iram_loadable.sv
// Run-time loadable instruction RAM: combinational fetch port plus a byte-stream
// loader that writes the image from entry 0 upward and zero-fills the rest.
//   state | meaning
//   IDLE  | no load active; LD_START begins one
//   RECV  | accepting bytes, writing assembled words, dropping overflow bytes
//   FILL  | writing zero to each remaining entry, one per cycle
module iram_loadable
  import iram_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  input  logic [ADDR_W-1:0]      ADDR,
  output logic [DATA_W-1:0]      Q,
  input  logic                   LD_START,
  input  logic                   LD_VALID,
  input  logic [7:0]             LD_DATA,
  input  logic                   LD_LAST,
  output logic                   LD_READY,
  output logic                   BUSY,
  output logic                   LD_DONE,
  output logic                   LD_ERR,
  output logic [$clog2(DEPTH):0] LD_COUNT
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;
  localparam int OFF_W = off_w(DATA_W);
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  LAST_C  = CNT_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_A = (ADDR_W + 1)'(DEPTH);

  ld_state_t         state_q, state_d;
  logic [CNT_W-1:0]  wptr_q, wptr_d, wptr_inc;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              done_q, done_d;
  logic              busy_q;
  logic              pk_clr, pk_valid, word_valid;
  logic [DATA_W-1:0] word;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [ADDR_W-1:0] fetch_idx;

  logic [DATA_W-1:0] mem [DEPTH];

  iram_byte_packer #(.DATA_W(DATA_W)) u_packer (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .clr       (pk_clr),
    .byte_valid(pk_valid),
    .byte_data (LD_DATA),
    .byte_last (LD_LAST),
    .word_valid(word_valid),
    .word      (word)
  );

  always_comb begin
    state_d   = state_q;
    wptr_d    = wptr_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    done_d    = 1'b0;
    pk_clr    = 1'b0;
    pk_valid  = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = word;
    wptr_inc  = wptr_q + 1'b1;
    unique case (state_q)
      IDLE: begin
        if (LD_START) begin
          state_d = RECV;
          wptr_d  = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
          pk_clr  = 1'b1;
        end
      end
      RECV: begin
        if (LD_VALID) begin
          if (wptr_q == DEPTH_C) begin
            // Full: drop the byte but keep draining the source until LD_LAST.
            err_d = 1'b1;
            if (LD_LAST) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else begin
            pk_valid = 1'b1;
            if (word_valid) begin
              mem_we = 1'b1;
              wptr_d = wptr_inc;
              cnt_d  = cnt_q + 1'b1;
              if (LD_LAST) begin
                if (wptr_inc < DEPTH_C) begin
                  state_d = FILL;
                end else begin
                  state_d = IDLE;
                  done_d  = 1'b1;
                end
              end
            end
          end
        end
      end
      FILL: begin
        mem_we    = 1'b1;
        mem_wdata = '0;
        wptr_d    = wptr_inc;
        if (wptr_q == LAST_C) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      done_q  <= done_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  // RAM array has no reset: contents survive RESET_N, including an aborted load.
  always_ff @(posedge CLK) begin
    if (mem_we) mem[wptr_q[IDX_W-1:0]] <= mem_wdata;
  end

  assign fetch_idx = ADDR >> OFF_W;

  always_comb begin
    Q = '0;
    if ({1'b0, fetch_idx} < DEPTH_A) Q = mem[fetch_idx[IDX_W-1:0]];
  end

  assign LD_READY = (state_q == RECV);
  assign BUSY     = busy_q;
  assign LD_DONE  = done_q;
  assign LD_ERR   = err_q;
  assign LD_COUNT = cnt_q;

endmodule
